// File: rtl/cnn_result_argmax.sv
// Argmax over N_CLASS signed classifier results: captures a set, scans it one channel per cycle.
// Latency: accept edge k -> class_valid high in the cycle after edge k+N_CLASS; next accept at k+N_CLASS+1.
// Backpressure: result_ready is high only in IDLE; result_valid seen while busy is dropped and counted.
//
// Ports:
//   clk_50M, reset_n          clock, asynchronous active-low reset
//   result_bus/_valid/_ready  flattened result set (channel i at [i*RES_W +: RES_W]) with handshake
//   class_idx, class_max      winning channel index and its signed value, held between updates
//   class_valid               one-cycle pulse when class_idx/class_max update
//   overrun_cnt               saturating count of cycles result_valid was high while busy
//   led                       class_idx zero-extended/truncated to 4 bits
//   dbg_trig                  only with CNN_ARGMAX_DBG_TRIG_EN: captured channels from bit 0, then
//                             class_idx, rest zero (requires N_CLASS*RES_W+IDX_W <= 256)
module cnn_result_argmax #(
    parameter int N_CLASS = 10,
    parameter int RES_W   = 23,
    parameter int IDX_W   = 4
) (
    input  logic                       clk_50M,
    input  logic                       reset_n,
    input  logic [N_CLASS*RES_W-1:0]   result_bus,
    input  logic                       result_valid,
    output logic                       result_ready,
    output logic [IDX_W-1:0]           class_idx,
    output logic [RES_W-1:0]           class_max,
    output logic                       class_valid,
    output logic [7:0]                 overrun_cnt,
    output logic [3:0]                 led
`ifdef CNN_ARGMAX_DBG_TRIG_EN
    ,
    output logic [255:0]               dbg_trig
`endif
);

    // Internal pointers are sized to the channel count so array selects match exactly.
    localparam int PTR_W = $clog2(N_CLASS);
    localparam int EXT_W = (IDX_W > 4) ? IDX_W : 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    logic signed [RES_W-1:0] cap [N_CLASS];
    logic [PTR_W-1:0]        ptr;
    logic [PTR_W-1:0]        best_idx;
    logic signed [RES_W-1:0] best_val;
    logic [EXT_W-1:0]        idx_ext;

    assign result_ready = (state == IDLE);

    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            for (int i = 0; i < N_CLASS; i++) begin
                cap[i] <= '0;
            end
            ptr         <= '0;
            best_idx    <= '0;
            best_val    <= '0;
            class_idx   <= '0;
            class_max   <= '0;
            class_valid <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            class_valid <= 1'b0;

            // Sets offered while busy are dropped; count every such cycle, saturating.
            if (result_valid && (state != IDLE) && (overrun_cnt != 8'hFF)) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (result_valid) begin
                        for (int i = 0; i < N_CLASS; i++) begin
                            cap[i] <= result_bus[i*RES_W +: RES_W];
                        end
                        // Channel 0 seeds the running best, so the scan starts at channel 1.
                        best_val <= result_bus[RES_W-1:0];
                        best_idx <= '0;
                        ptr      <= PTR_W'(1);
                        state    <= SCAN;
                    end
                end

                SCAN: begin
                    // Strictly greater only: ties keep the lower index already held.
                    if (cap[ptr] > best_val) begin
                        best_val <= cap[ptr];
                        best_idx <= ptr;
                    end
                    ptr <= ptr + 1'b1;
                    if (ptr == PTR_W'(N_CLASS - 1)) begin
                        state <= DONE;
                    end
                end

                DONE: begin
                    class_idx   <= IDX_W'(best_idx);
                    class_max   <= best_val;
                    class_valid <= 1'b1;
                    state       <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign idx_ext = EXT_W'(class_idx);
    assign led     = idx_ext[3:0];

`ifdef CNN_ARGMAX_DBG_TRIG_EN
    always_comb begin
        dbg_trig = '0;
        for (int i = 0; i < N_CLASS; i++) begin
            dbg_trig[i*RES_W +: RES_W] = cap[i];
        end
        dbg_trig[N_CLASS*RES_W +: IDX_W] = class_idx;
    end
`endif

endmodule

// File: tb/tb_cnn_result_argmax.sv
// Directed and randomized bench for cnn_result_argmax at default parameters.
// Expected winners come from a plain first-maximum search over an int array.
module tb_cnn_result_argmax;

    localparam int N  = 10;
    localparam int W  = 23;
    localparam int IW = 4;
    localparam int BW = N * W;

    logic          clk_50M      = 1'b0;
    logic          reset_n      = 1'b0;
    logic [BW-1:0] result_bus   = '0;
    logic          result_valid = 1'b0;
    logic          result_ready;
    logic [IW-1:0] class_idx;
    logic [W-1:0]  class_max;
    logic          class_valid;
    logic [7:0]    overrun_cnt;
    logic [3:0]    led;

    int checks     = 0;
    int failures   = 0;
    int cyc        = 0;
    int last_pulse = 0;
    int vals [N];

    cnn_result_argmax #(.N_CLASS(N), .RES_W(W), .IDX_W(IW)) dut (
        .clk_50M      (clk_50M),
        .reset_n      (reset_n),
        .result_bus   (result_bus),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .class_idx    (class_idx),
        .class_max    (class_max),
        .class_valid  (class_valid),
        .overrun_cnt  (overrun_cnt),
        .led          (led)
    );

    always #10 clk_50M = ~clk_50M;

    always @(posedge clk_50M) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] pack_vals();
        logic [BW-1:0] b;
        b = '0;
        for (int i = 0; i < N; i++) begin
            b[i*W +: W] = W'(vals[i]);
        end
        return b;
    endfunction

    // Reference: first index holding the maximum value.
    function automatic int ref_idx();
        int best;
        best = 0;
        for (int i = 1; i < N; i++) begin
            if (vals[i] > vals[best]) best = i;
        end
        return best;
    endfunction

    // Present vals for one cycle; returns #1 after the accepting edge.
    task automatic accept(input string tag);
        result_bus   = pack_vals();
        result_valid = 1'b1;
        check({tag, "_ready"}, 32'(result_ready), 32'd1);
        @(posedge clk_50M);
        #1;
        result_valid = 1'b0;
    endtask

    // Wait (bounded) for class_valid; exp_lat counts edges from the call point.
    task automatic wait_result(input string tag, input int exp_lat, input int exp_idx, input int exp_max);
        int j;
        j = 0;
        check({tag, "_busy"}, 32'(result_ready), 32'd0);
        do begin
            @(posedge clk_50M);
            #1;
            j++;
        end while (!class_valid && j < 40);
        last_pulse = cyc;
        check({tag, "_lat"}, 32'(j), 32'(exp_lat));
        check({tag, "_idx"}, 32'(class_idx), 32'(exp_idx));
        check({tag, "_max"}, 32'(class_max), exp_max & 32'h7FFFFF);
        check({tag, "_led"}, 32'(led), exp_idx & 32'hF);
    endtask

    task automatic check_hold(input string tag, input int exp_idx, input int exp_max);
        @(posedge clk_50M);
        #1;
        check({tag, "_pulse1"}, 32'(class_valid), 32'd0);
        check({tag, "_hold_idx"}, 32'(class_idx), 32'(exp_idx));
        check({tag, "_hold_max"}, 32'(class_max), exp_max & 32'h7FFFFF);
    endtask

    initial begin
        int e_idx;
        int e_max;
        int p1;

        // Reset state
        repeat (3) @(posedge clk_50M);
        #1;
        check("rst_ready", 32'(result_ready), 32'd1);
        check("rst_valid", 32'(class_valid), 32'd0);
        check("rst_idx",   32'(class_idx),   32'd0);
        check("rst_max",   32'(class_max),   32'd0);
        check("rst_ovr",   32'(overrun_cnt), 32'd0);
        check("rst_led",   32'(led),         32'd0);
        reset_n = 1'b1;
        @(posedge clk_50M);
        #1;

        // Mixed values with a tie at the maximum
        vals = '{5, 17, -3, 40, 2, 40, 0, -100, 39, 1};
        accept("t30");
        wait_result("t30", 10, 3, 40);
        check_hold("t30", 3, 40);

        // All negative, tie at -1 resolves to channel 0
        for (int i = 0; i < N; i++) vals[i] = -1;
        vals[9] = -2;
        accept("t31");
        wait_result("t31", 10, 0, -1);
        check_hold("t31", 0, -1);

        // Extremes of the signed range
        for (int i = 0; i < N; i++) vals[i] = -4194304;
        vals[9] = 4194303;
        accept("t32");
        wait_result("t32", 10, 9, 4194303);
        check_hold("t32", 9, 4194303);

        // valid held 4 cycles from accept, bus scrambled during scan
        for (int i = 0; i < N; i++) vals[i] = int'($urandom_range(0, 2000)) - 1000;
        e_idx = ref_idx();
        e_max = vals[e_idx];
        result_bus   = pack_vals();
        result_valid = 1'b1;
        @(posedge clk_50M);
        #1;
        for (int i = 0; i < 3; i++) begin
            result_bus = ~result_bus;
            @(posedge clk_50M);
            #1;
        end
        result_valid = 1'b0;
        wait_result("t33", 7, e_idx, e_max);
        check("t33_ovr", 32'(overrun_cnt), 32'd3);

        // Reset 5 cycles into a scan
        vals = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        accept("t34a");
        repeat (5) begin
            @(posedge clk_50M);
            #1;
        end
        reset_n = 1'b0;
        #1;
        check("t34_ready", 32'(result_ready), 32'd1);
        check("t34_valid", 32'(class_valid), 32'd0);
        check("t34_idx",   32'(class_idx),   32'd0);
        check("t34_max",   32'(class_max),   32'd0);
        check("t34_ovr",   32'(overrun_cnt), 32'd0);
        check("t34_led",   32'(led),         32'd0);
        repeat (3) @(posedge clk_50M);
        #1;
        reset_n = 1'b1;
        vals = '{0, 0, 0, 0, 0, 0, 0, 7, 0, 0};
        accept("t34b");
        wait_result("t34b", 10, 7, 7);

        // Back-to-back: second set offered in the class_valid cycle
        vals = '{3, 9, 1, 9, 0, 0, 0, 0, 0, -5};
        accept("t35a");
        wait_result("t35a", 10, 1, 9);
        p1 = last_pulse;
        vals = '{-8, -7, -6, -5, -4, -3, -2, -1, 0, 100};
        accept("t35b");
        wait_result("t35b", 10, 9, 100);
        check("t35_gap", 32'(last_pulse - p1), 32'd11);
        check("t35_ovr", 32'(overrun_cnt), 32'd0);

        // Randomized sets, alternating narrow (tie-heavy) and full-range values
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < N; i++) begin
                if (t % 2 == 0) vals[i] = int'($urandom_range(0, 8)) - 4;
                else            vals[i] = int'($urandom_range(0, 8388607)) - 4194304;
            end
            e_idx = ref_idx();
            e_max = vals[e_idx];
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk_50M);
                #1;
            end
            accept("rnd");
            wait_result("rnd", 10, e_idx, e_max);
            check_hold("rnd", e_idx, e_max);
        end
        check("rnd_ovr", 32'(overrun_cnt), 32'd0);

        // Continuous valid: overrun count saturates
        result_bus   = {BW{1'b1}};
        result_valid = 1'b1;
        repeat (300) @(posedge clk_50M);
        #1;
        result_valid = 1'b0;
        repeat (15) @(posedge clk_50M);
        #1;
        check("sat_ovr", 32'(overrun_cnt), 32'd255);
        check("sat_ready", 32'(result_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
